// File: rtl/bus_rr_scheduler.sv
// bus_rr_scheduler: round-robin scheduler sharing one packet bus among DRVS driver FIFOs.
// Grants one pending source, pops a packet from it, decodes the destination ID from the
// packet MSBs and pushes it to one driver, or to every other driver on broadcast.
// Undeliverable packets (bad/self destination, or backpressure past TIMEOUT) are dropped.
//
// Ports:
//   clk      - clock, all logic on posedge
//   reset    - synchronous active-low reset
//   pndng    - per-driver FIFO non-empty
//   D_pop    - head packet of driver i at [i*PCKG_SZ +: PCKG_SZ]
//   pop      - one-hot, one-cycle pop strobe to the granted source
//   full     - per-driver input FIFO full
//   push     - push strobe: one-hot for unicast, mask for broadcast
//   D_push   - packet being delivered, valid while push != 0
//   busy     - high whenever the scheduler is not idle
//   grant_id - index of the current or last granted source
//   drop_cnt - saturating count of dropped packets
module bus_rr_scheduler #(
  parameter int unsigned DRVS    = 8,
  parameter int unsigned PCKG_SZ = 16,
  parameter logic [7:0]  BCAST   = 8'hFF,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DRVS-1:0]         pndng,
  input  logic [DRVS*PCKG_SZ-1:0] D_pop,
  output logic [DRVS-1:0]         pop,
  input  logic [DRVS-1:0]         full,
  output logic [DRVS-1:0]         push,
  output logic [PCKG_SZ-1:0]      D_push,
  output logic                    busy,
  output logic [7:0]              grant_id,
  output logic [15:0]             drop_cnt
);

  typedef enum logic [1:0] {StIdle, StPop, StRoute, StDeliver} state_e;

  localparam logic [DRVS-1:0] OneHot0 = DRVS'(1);
  localparam logic [7:0]      LastDrv = 8'(DRVS - 1);

  state_e               state_q, state_d;
  logic [DRVS-1:0]      pop_q, pop_d;
  logic [DRVS-1:0]      push_q, push_d;
  logic [PCKG_SZ-1:0]   d_push_q, d_push_d;
  logic                 busy_q, busy_d;
  logic [7:0]           grant_q, grant_d;
  logic [7:0]           rr_ptr_q, rr_ptr_d;
  logic [15:0]          drop_cnt_q, drop_cnt_d;
  logic [PCKG_SZ-1:0]   pkt_q, pkt_d;
  logic [DRVS-1:0]      mask_q, mask_d;
  logic [15:0]          wait_q, wait_d;

  logic                 found;
  logic [7:0]           grant_sel;
  logic [PCKG_SZ-1:0]   pop_pkt;
  logic [7:0]           dest;
  logic                 route_ok;
  logic [DRVS-1:0]      route_mask;
  logic                 drop;

  // Circular priority search: indices above rr_ptr first, then wrap to those at or below it.
  always_comb begin
    found     = 1'b0;
    grant_sel = '0;
    for (int unsigned i = 0; i < DRVS; i++) begin
      if (!found && pndng[i] && (8'(i) > rr_ptr_q)) begin
        found     = 1'b1;
        grant_sel = 8'(i);
      end
    end
    for (int unsigned i = 0; i < DRVS; i++) begin
      if (!found && pndng[i] && (8'(i) <= rr_ptr_q)) begin
        found     = 1'b1;
        grant_sel = 8'(i);
      end
    end
  end

  // Head packet of the granted source.
  always_comb begin
    pop_pkt = '0;
    for (int unsigned i = 0; i < DRVS; i++) begin
      if (grant_q == 8'(i)) begin
        pop_pkt = D_pop[i*PCKG_SZ +: PCKG_SZ];
      end
    end
  end

  // Destination decode of the captured packet.
  always_comb begin
    dest       = pkt_q[PCKG_SZ-1 -: 8];
    route_ok   = 1'b0;
    route_mask = '0;
    if (dest == BCAST) begin
      route_ok   = 1'b1;
      route_mask = ~(OneHot0 << grant_q);
    end else if ((32'(dest) < DRVS) && (dest != grant_q)) begin
      route_ok   = 1'b1;
      route_mask = OneHot0 << dest;
    end
  end

  always_comb begin
    state_d  = state_q;
    pop_d    = '0;
    push_d   = '0;
    d_push_d = '0;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    pkt_d    = pkt_q;
    mask_d   = mask_q;
    wait_d   = wait_q;
    drop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          grant_d  = grant_sel;
          rr_ptr_d = grant_sel;
          pop_d    = OneHot0 << grant_sel;
          state_d  = StPop;
        end
      end
      StPop: begin
        // The FIFO pops on this same edge, so its head is still on D_pop.
        pkt_d   = pop_pkt;
        state_d = StRoute;
      end
      StRoute: begin
        if (!route_ok) begin
          drop    = 1'b1;
          state_d = StIdle;
        end else begin
          mask_d  = route_mask;
          wait_d  = '0;
          state_d = StDeliver;
          // Push is registered; launching it here lets it appear in the first DELIVER cycle.
          if ((route_mask & full) == '0) begin
            push_d   = route_mask;
            d_push_d = pkt_q;
          end
        end
      end
      StDeliver: begin
        if (push_q != '0) begin
          state_d = StIdle;
        end else if ((mask_q & full) == '0) begin
          push_d   = mask_q;
          d_push_d = pkt_q;
        end else if ((32'(wait_q) + 32'd1) >= TIMEOUT) begin
          drop    = 1'b1;
          state_d = StIdle;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
    drop_cnt_d = (drop && (drop_cnt_q != 16'hFFFF)) ? drop_cnt_q + 16'd1 : drop_cnt_q;
    busy_d     = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      pop_q      <= '0;
      push_q     <= '0;
      d_push_q   <= '0;
      busy_q     <= 1'b0;
      grant_q    <= '0;
      rr_ptr_q   <= LastDrv;
      drop_cnt_q <= '0;
      pkt_q      <= '0;
      mask_q     <= '0;
      wait_q     <= '0;
    end else begin
      state_q    <= state_d;
      pop_q      <= pop_d;
      push_q     <= push_d;
      d_push_q   <= d_push_d;
      busy_q     <= busy_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      drop_cnt_q <= drop_cnt_d;
      pkt_q      <= pkt_d;
      mask_q     <= mask_d;
      wait_q     <= wait_d;
    end
  end

  assign pop      = pop_q;
  assign push     = push_q;
  assign D_push   = d_push_q;
  assign busy     = busy_q;
  assign grant_id = grant_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_bus_rr_scheduler.sv
// Bench for bus_rr_scheduler: directed scenarios plus a randomized run checked against a
// transaction-level model (round-robin pick, destination rules, nominal latencies).
module tb_bus_rr_scheduler;

  localparam int DRVS = 8;
  localparam int PSZ  = 16;
  localparam int TOUT = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [DRVS-1:0]   pndng = '0;
  logic [DRVS*PSZ-1:0] D_pop = '0;
  logic [DRVS-1:0]   pop;
  logic [DRVS-1:0]   full = '0;
  logic [DRVS-1:0]   push;
  logic [PSZ-1:0]    D_push;
  logic              busy;
  logic [7:0]        grant_id;
  logic [15:0]       drop_cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [PSZ-1:0]  srcq [DRVS][$];
  logic [DRVS-1:0] pndng_prev = '0;

  bus_rr_scheduler #(
    .DRVS    (DRVS),
    .PCKG_SZ (PSZ),
    .BCAST   (8'hFF),
    .TIMEOUT (TOUT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .pndng    (pndng),
    .D_pop    (D_pop),
    .pop      (pop),
    .full     (full),
    .push     (push),
    .D_push   (D_push),
    .busy     (busy),
    .grant_id (grant_id),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // Source FIFO emulation: pndng/D_pop mirror the queue heads.
  task automatic drive_src();
    for (int i = 0; i < DRVS; i++) begin
      pndng[i] = (srcq[i].size() > 0);
      D_pop[i*PSZ +: PSZ] = (srcq[i].size() > 0) ? srcq[i][0] : '0;
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    logic [DRVS-1:0] p;
    p = pop;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < DRVS; i++) begin
      if (p[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
    end
    pndng_prev = pndng;
    drive_src();
  endtask

  task automatic clear_env();
    for (int i = 0; i < DRVS; i++) srcq[i].delete();
    full = '0;
    drive_src();
  endtask

  task automatic do_reset();
    clear_env();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  // Steps until pop is seen; c = cycle of the pop or -1 if the budget ran out.
  task automatic wait_pop(input int limit, output int c);
    c = -1;
    for (int n = 0; n < limit; n++) begin
      if (pop != '0) begin
        c = cyc;
        return;
      end
      step();
    end
  endtask

  function automatic int rr_pick(input logic [DRVS-1:0] p, input int last);
    for (int k = 1; k <= DRVS; k++) begin
      if (p[(last + k) % DRVS]) return (last + k) % DRVS;
    end
    return -1;
  endfunction

  task automatic test_reset();
    int c;
    clear_env();
    for (int i = 0; i < DRVS; i++) srcq[i].push_back({8'((i + 1) % DRVS), 8'(8'hA0 + i)});
    drive_src();
    reset = 1'b0;
    for (int n = 0; n < 3; n++) begin
      step();
      total++;
      if ({pop, push, busy, drop_cnt, grant_id} !== '0) begin
        bad++;
        $display("FAIL reset_hold: pop=%h push=%h busy=%b drop=%h grant=%h, all must be 0",
                 pop, push, busy, drop_cnt, grant_id);
      end
    end
    reset = 1'b1;
    wait_pop(8, c);
    total++;
    if (c < 0 || pop !== 8'h01 || grant_id !== 8'd0) begin
      bad++;
      $display("FAIL reset_first_grant: pop=%h grant=%0d expected pop=01 grant=0", pop, grant_id);
    end
  endtask

  task automatic test_unicast();
    int c;
    do_reset();
    srcq[2].push_back(16'h05AB);
    drive_src();
    wait_pop(10, c);
    total++;
    if (c < 0 || pop !== 8'h04) begin
      bad++;
      $display("FAIL uni_pop: got %h expected 04", pop);
    end
    step();
    total++;
    if (pop !== 8'h00 || push !== 8'h00) begin
      bad++;
      $display("FAIL uni_gap: pop=%h push=%h expected 00/00", pop, push);
    end
    step();
    total++;
    if (push !== 8'h20 || D_push !== 16'h05AB) begin
      bad++;
      $display("FAIL uni_push: push=%h data=%h expected 20/05ab", push, D_push);
    end
    step();
    total++;
    if (push !== 8'h00 || busy !== 1'b0) begin
      bad++;
      $display("FAIL uni_after: push=%h busy=%b expected 00/0", push, busy);
    end
  endtask

  task automatic test_round_robin();
    int c;
    int prev;
    do_reset();
    for (int i = 0; i < DRVS; i++) begin
      for (int k = 0; k < 2; k++) srcq[i].push_back({8'((i + 1) % DRVS), 8'(i * 16 + k)});
    end
    drive_src();
    prev = -1;
    for (int g = 0; g <= DRVS; g++) begin
      wait_pop(10, c);
      total++;
      if (c < 0 || grant_id !== 8'(g % DRVS) || pop !== (8'h01 << (g % DRVS))) begin
        bad++;
        $display("FAIL rr_grant[%0d]: grant=%0d pop=%h expected grant=%0d", g, grant_id, pop,
                 g % DRVS);
      end
      if (g > 0) begin
        total++;
        if (c - prev != 4) begin
          bad++;
          $display("FAIL rr_spacing[%0d]: got %0d cycles expected 4", g, c - prev);
        end
      end
      prev = c;
      step();
    end
  endtask

  task automatic test_broadcast();
    int c;
    do_reset();
    srcq[3].push_back(16'hFF12);
    drive_src();
    wait_pop(10, c);
    total++;
    if (c < 0 || pop !== 8'h08) begin
      bad++;
      $display("FAIL bc_pop: got %h expected 08", pop);
    end
    step();
    step();
    total++;
    if (push !== 8'hF7 || D_push !== 16'hFF12) begin
      bad++;
      $display("FAIL bc_push: push=%h data=%h expected f7/ff12", push, D_push);
    end
    step();
    total++;
    if (push !== 8'h00) begin
      bad++;
      $display("FAIL bc_single: push=%h expected 00", push);
    end
    // Same packet with full[5] held for 5 cycles starting where the push would be decided.
    do_reset();
    srcq[3].push_back(16'hFF12);
    drive_src();
    wait_pop(10, c);
    step();
    full = 8'h20;
    for (int n = 1; n <= 5; n++) begin
      total++;
      if (push !== 8'h00 || busy !== 1'b1) begin
        bad++;
        $display("FAIL bc_blocked[%0d]: push=%h busy=%b expected 00/1", n, push, busy);
      end
      step();
    end
    full = 8'h00;
    total++;
    if (push !== 8'h00) begin
      bad++;
      $display("FAIL bc_blocked_last: push=%h expected 00", push);
    end
    step();
    total++;
    if (push !== 8'hF7 || D_push !== 16'hFF12) begin
      bad++;
      $display("FAIL bc_delayed_push: push=%h data=%h expected f7/ff12", push, D_push);
    end
    step();
    total++;
    if (push !== 8'h00 || busy !== 1'b0) begin
      bad++;
      $display("FAIL bc_delayed_after: push=%h busy=%b expected 00/0", push, busy);
    end
  endtask

  task automatic test_drops();
    int c;
    int seen_push;
    do_reset();
    srcq[0].push_back(16'h0900);
    drive_src();
    wait_pop(10, c);
    seen_push = 0;
    for (int n = 0; n < 4; n++) begin
      step();
      if (push !== 8'h00) seen_push++;
    end
    total++;
    if (c < 0 || seen_push != 0 || drop_cnt !== 16'd1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL drop_range: drop=%0d pushes=%0d busy=%b expected 1/0/0", drop_cnt,
               seen_push, busy);
    end
    srcq[4].push_back(16'h0400);
    drive_src();
    wait_pop(10, c);
    total++;
    if (c < 0 || pop !== 8'h10) begin
      bad++;
      $display("FAIL drop_self_pop: pop=%h expected 10", pop);
    end
    seen_push = 0;
    for (int n = 0; n < 4; n++) begin
      step();
      if (push !== 8'h00) seen_push++;
    end
    total++;
    if (seen_push != 0 || drop_cnt !== 16'd2) begin
      bad++;
      $display("FAIL drop_self: drop=%0d pushes=%0d expected 2/0", drop_cnt, seen_push);
    end
    srcq[2].push_back(16'h0155);
    full = 8'h02;
    drive_src();
    wait_pop(10, c);
    seen_push = 0;
    for (int n = 1; n <= TOUT; n++) begin
      step();
      if (push !== 8'h00) seen_push++;
    end
    total++;
    if (c < 0 || drop_cnt !== 16'd2 || busy !== 1'b1) begin
      bad++;
      $display("FAIL drop_timeout_early: drop=%0d busy=%b expected 2/1", drop_cnt, busy);
    end
    for (int n = 0; n < 6 && drop_cnt !== 16'd3; n++) begin
      step();
      if (push !== 8'h00) seen_push++;
    end
    step();
    total++;
    if (drop_cnt !== 16'd3 || seen_push != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL drop_timeout: drop=%0d pushes=%0d busy=%b expected 3/0/0", drop_cnt,
               seen_push, busy);
    end
    full = 8'h00;
  endtask

  task automatic test_reset_mid_deliver();
    int c;
    do_reset();
    srcq[0].push_back(16'h0900);
    srcq[2].push_back(16'h0155);
    full = 8'h02;
    drive_src();
    for (int n = 0; n < 12; n++) step();
    total++;
    if (drop_cnt !== 16'd1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_setup: drop=%0d busy=%b expected 1/1", drop_cnt, busy);
    end
    reset = 1'b0;
    step();
    reset = 1'b1;
    full = 8'h00;
    total++;
    if (pop !== 8'h00 || push !== 8'h00 || busy !== 1'b0 || drop_cnt !== 16'd0) begin
      bad++;
      $display("FAIL mid_reset: pop=%h push=%h busy=%b drop=%0d expected 00/00/0/0", pop,
               push, busy, drop_cnt);
    end
    // Drivers 1 and 3 pending: restored pointer gives 1, the stale pointer (2) would give 3.
    srcq[1].push_back(16'h0355);
    srcq[3].push_back(16'h0455);
    drive_src();
    wait_pop(10, c);
    total++;
    if (c < 0 || grant_id !== 8'd1 || pop !== 8'h02 || push !== 8'h00) begin
      bad++;
      $display("FAIL mid_regrant: grant=%0d pop=%h push=%h expected 1/02/00", grant_id, pop,
               push);
    end
    step();
    total++;
    if (push !== 8'h00) begin
      bad++;
      $display("FAIL mid_no_stale_push: push=%h expected 00", push);
    end
    step();
    total++;
    if (push !== 8'h08 || D_push !== 16'h0355) begin
      bad++;
      $display("FAIL mid_new_push: push=%h data=%h expected 08/0355", push, D_push);
    end
  endtask

  task automatic test_random();
    int last;
    int idle_from;
    int exp_cyc;
    int dropm;
    int g;
    logic [DRVS-1:0] exp_mask;
    logic [PSZ-1:0]  exp_data;
    logic [PSZ-1:0]  pkt;
    logic [7:0]      dest;
    do_reset();
    last      = DRVS - 1;
    idle_from = cyc;
    exp_cyc   = -1;
    dropm     = 0;
    exp_mask  = '0;
    exp_data  = '0;
    for (int n = 0; n < 500; n++) begin
      step();
      if ((cyc - 1 >= idle_from) && (pndng_prev != '0)) begin
        g = rr_pick(pndng_prev, last);
        total++;
        if (pop !== (8'h01 << g) || grant_id !== 8'(g)) begin
          bad++;
          $display("FAIL rand_grant@%0d: pop=%h grant=%0d expected grant=%0d", cyc, pop,
                   grant_id, g);
        end
        last = g;
        pkt  = (srcq[g].size() > 0) ? srcq[g][0] : '0;
        dest = pkt[PSZ-1 -: 8];
        if (dest == 8'hFF) begin
          exp_mask = ~(8'h01 << g);
        end else if (dest < DRVS && int'(dest) != g) begin
          exp_mask = 8'h01 << dest;
        end else begin
          exp_mask = '0;
        end
        if (exp_mask != '0) begin
          exp_cyc   = cyc + 2;
          exp_data  = pkt;
          idle_from = cyc + 3;
        end else begin
          dropm++;
          idle_from = cyc + 2;
        end
      end else begin
        total++;
        if (pop !== 8'h00) begin
          bad++;
          $display("FAIL rand_nopop@%0d: pop=%h expected 00", cyc, pop);
        end
      end
      total++;
      if (cyc == exp_cyc) begin
        if (push !== exp_mask || D_push !== exp_data) begin
          bad++;
          $display("FAIL rand_push@%0d: push=%h data=%h expected %h/%h", cyc, push, D_push,
                   exp_mask, exp_data);
        end
      end else if (push !== 8'h00) begin
        bad++;
        $display("FAIL rand_nopush@%0d: push=%h expected 00", cyc, push);
      end
      if (n < 400 && $urandom_range(0, 99) < 30) begin
        int src;
        int sel;
        src = $urandom_range(0, DRVS - 1);
        sel = $urandom_range(0, 9);
        if (sel < 7)       dest = 8'($urandom_range(0, DRVS - 1));
        else if (sel == 7) dest = 8'hFF;
        else if (sel == 8) dest = 8'($urandom_range(DRVS, 254));
        else               dest = 8'(src);
        if (srcq[src].size() < 4) srcq[src].push_back({dest, 8'($urandom_range(0, 255))});
      end
    end
    total++;
    if (drop_cnt !== 16'(dropm) || busy !== 1'b0) begin
      bad++;
      $display("FAIL rand_drops: drop=%0d busy=%b expected %0d/0", drop_cnt, busy, dropm);
    end
  endtask

  initial begin
    drive_src();
    test_reset();
    test_unicast();
    test_round_robin();
    test_broadcast();
    test_drops();
    test_reset_mid_deliver();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
